// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin write arbiter that shares one fwft_fifo write port among N_REQ
//   valid/ready producers. A producer gets a registered one-hot grant and may
//   transfer up to MAX_BURST words on it. The grant is then released and the
//   round-robin pointer moves past it. There is one idle cycle between bursts.
//
// Ports
//   clk        in   clock, single domain
//   rst        in   synchronous active-high reset
//   req_valid  in   [N_REQ]             per-requester word valid
//   req_data   in   [N_REQ*DATA_WIDTH]  requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  out  [N_REQ]             per-requester accept (transfer = valid & ready)
//   grant      out  [N_REQ]             one-hot registered grant, zero when idle
//   wr_en      out  fwft_fifo write enable
//   din        out  [DATA_WIDTH]        fwft_fifo write data, zero when wr_en is low
//   full       in   fwft_fifo full flag
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic [N_REQ-1:0]              grant,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         din,
  input  logic                          full
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [N_REQ-1:0]        r_grant;
  logic [N_REQ-1:0]        w_grant_nxt;
  logic [IW-1:0]           r_gidx;
  logic [IW-1:0]           w_gidx_nxt;
  logic [IW-1:0]           r_ptr;
  logic [IW-1:0]           w_ptr_nxt;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           w_cnt_nxt;

  logic                    w_gvalid;
  logic [DATA_WIDTH-1:0]   w_gdata;
  logic                    w_xfer;
  logic                    w_last;
  logic [IW-1:0]           w_pick;

  // (p + k) mod N_REQ without a divider; p < N_REQ and k < N_REQ.
  function automatic logic [IW-1:0] f_wrap_add(input logic [IW-1:0] p, input int k);
    logic [IW:0] s;
    s = {1'b0, p} + (IW+1)'(k);
    if (s >= (IW+1)'(N_REQ)) s = s - (IW+1)'(N_REQ);
    return s[IW-1:0];
  endfunction

  // First valid index searching p, p+1, ... mod N_REQ. Scanning k downward lets
  // the smallest offset win the last assignment.
  function automatic logic [IW-1:0] f_rr_pick(input logic [N_REQ-1:0] v, input logic [IW-1:0] p);
    logic [IW-1:0] idx;
    logic [IW-1:0] cand;
    idx = p;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = f_wrap_add(p, k);
      if (v[cand]) idx = cand;
    end
    return idx;
  endfunction

  // Granted requester's valid and data. A mux loop avoids a multiply in the part-select.
  always_comb begin
    w_gvalid = 1'b0;
    w_gdata  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_gidx == IW'(i)) begin
        w_gvalid = req_valid[i];
        w_gdata  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_xfer = (r_state == ST_BURST) && w_gvalid && !full;
  assign w_last = (r_cnt == CW'(MAX_BURST - 1));
  assign w_pick = f_rr_pick(req_valid, r_ptr);

  // The write port sees only the granted requester. Ready follows full so that
  // nothing is accepted while the FIFO cannot take it.
  always_comb begin
    req_ready = '0;
    wr_en     = 1'b0;
    din       = '0;
    if (r_state == ST_BURST) begin
      req_ready = full ? '0 : r_grant;
      wr_en     = w_xfer;
      din       = w_xfer ? w_gdata : '0;
    end
  end

  assign grant = r_grant;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (|req_valid) begin
          w_state_nxt = ST_BURST;
          w_gidx_nxt  = w_pick;
          w_grant_nxt = N_REQ'(1) << w_pick;
          w_cnt_nxt   = '0;
        end
      end
      ST_BURST: begin
        // The burst ends on its last word, or when the owner has nothing to
        // offer. A valid drop while full also releases, so a stalled producer
        // cannot hold the port.
        if ((w_xfer && w_last) || !w_gvalid) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_cnt_nxt   = '0;
          w_ptr_nxt   = f_wrap_add(r_gidx, 1);
        end else if (w_xfer) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        wr_en;
  logic [7:0]  din;
  logic        full;

  fifo_wr_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant(grant), .wr_en(wr_en), .din(din), .full(full)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Producer sequence numbers, read-side expectations, word limits.
  int seq[4];
  int exp_seq[4];
  int lim[4];
  // FIFO model on the write side.
  logic [7:0] fq[$];
  int  depth;
  bit  pop_en;
  // Reference arbiter: owner (-1 = none), rr pointer, words in the current burst.
  int m_own, m_ptr, m_cnt;
  // Burst log.
  logic [3:0] prev_gnt;
  int         bw;
  logic [3:0] glog[$];
  int         blog[$];
  logic       last_wr;
  logic [3:0] last_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop();
    logic [7:0] w;
    int id;
    w  = fq.pop_front();
    id = int'(w[7:4]);
    if (id < 4) begin
      chk("rd_order", 32'(w[3:0]), 32'(exp_seq[id] % 16));
      exp_seq[id]++;
    end else begin
      chk("rd_id", 32'(id), 32'(0));
    end
  endtask

  task automatic step(input logic [3:0] vmask, input logic ff, input logic r);
    logic [3:0] e_gnt, e_rdy;
    logic       e_wr;
    logic [7:0] e_din;
    int         k, c;
    @(negedge clk);
    rst = r;
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = vmask[i] && (seq[i] < lim[i]);
      req_data[i*8 +: 8] = {4'(i), 4'(seq[i] % 16)};
    end
    full = ff || (fq.size() >= depth);
    #1;
    e_gnt = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0000;
    e_rdy = (m_own >= 0 && !full) ? e_gnt : 4'b0000;
    e_wr  = (m_own >= 0) && req_valid[m_own] && !full;
    e_din = e_wr ? {4'(m_own), 4'(seq[m_own] % 16)} : 8'h00;
    chk("grant", 32'(grant), 32'(e_gnt));
    chk("ready", 32'(req_ready), 32'(e_rdy));
    chk("wr_en", 32'(wr_en), 32'(e_wr));
    chk("din", 32'(din), 32'(e_din));
    chk("wr_full", 32'(wr_en & full), 32'(0));
    chk("onehot", 32'($onehot0(grant)), 32'(1));
    last_wr  = wr_en;
    last_gnt = grant;
    // Burst log from the observed outputs.
    if (grant != 0 && prev_gnt == 0) begin glog.push_back(grant); bw = 0; end
    if (grant != 0 && wr_en) bw++;
    if (grant == 0 && prev_gnt != 0) blog.push_back(bw);
    prev_gnt = grant;
    // Handshakes and FIFO traffic at the coming edge.
    for (int i = 0; i < 4; i++) if (req_valid[i] && req_ready[i]) seq[i]++;
    if (pop_en && fq.size() > 0 && $urandom_range(0, 1) == 1) sb_pop();
    if (wr_en) fq.push_back(din);
    // Reference arbiter advance.
    if (r) begin
      m_own = -1; m_ptr = 0; m_cnt = 0;
    end else if (m_own < 0) begin
      if (req_valid != 0) begin
        c = -1;
        for (k = 3; k >= 0; k--) if (req_valid[(m_ptr + k) % 4]) c = (m_ptr + k) % 4;
        m_own = c; m_cnt = 0;
      end
    end else if (e_wr) begin
      m_cnt++;
      if (m_cnt == 4) begin m_ptr = (m_own + 1) % 4; m_own = -1; m_cnt = 0; end
    end else if (!req_valid[m_own]) begin
      m_ptr = (m_own + 1) % 4; m_own = -1; m_cnt = 0;
    end
  endtask

  task automatic restart(input int d, input bit pe);
    while (fq.size() > 0) sb_pop();
    for (int i = 0; i < 4; i++) begin seq[i] = 0; exp_seq[i] = 0; lim[i] = 0; end
    depth = d; pop_en = pe;
    step(4'h0, 1'b0, 1'b1);
    glog.delete(); blog.delete(); prev_gnt = 4'h0; bw = 0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; full = 1'b0;
    for (int i = 0; i < 4; i++) begin seq[i] = 0; exp_seq[i] = 0; lim[i] = 0; end
    depth = 16; pop_en = 0;
    m_own = -1; m_ptr = 0; m_cnt = 0; prev_gnt = 4'h0; bw = 0;
    repeat (2) @(posedge clk);
    // Reset state.
    step(4'h0, 1'b0, 1'b0);
    chk("rst_gnt", 32'(last_gnt), 32'(0));

    // Single requester, 10 words: bursts 4,4,2, first write one cycle after valid.
    restart(16, 0);
    lim[0] = 10;
    step(4'h1, 1'b0, 1'b0);
    chk("t1_lat0", 32'(last_wr), 32'(0));
    step(4'h1, 1'b0, 1'b0);
    chk("t1_lat1", 32'(last_wr), 32'(1));
    repeat (18) step(4'h1, 1'b0, 1'b0);
    chk("t1_nb", 32'(blog.size()), 32'(3));
    if (blog.size() == 3) begin
      chk("t1_b0", 32'(blog[0]), 32'(4));
      chk("t1_b1", 32'(blog[1]), 32'(4));
      chk("t1_b2", 32'(blog[2]), 32'(2));
    end

    // All four valid: grant order 1,2,4,8,1 and FIFO contents in order.
    restart(16, 0);
    lim[0] = 8; lim[1] = 4; lim[2] = 4; lim[3] = 4;
    repeat (30) step(4'hF, 1'b0, 1'b0);
    chk("t2_ng", 32'(glog.size()), 32'(5));
    if (glog.size() == 5) begin
      chk("t2_g0", 32'(glog[0]), 32'h1);
      chk("t2_g1", 32'(glog[1]), 32'h2);
      chk("t2_g2", 32'(glog[2]), 32'h4);
      chk("t2_g3", 32'(glog[3]), 32'h8);
      chk("t2_g4", 32'(glog[4]), 32'h1);
    end
    chk("t2_fill", 32'(fq.size()), 32'(16));
    if (fq.size() == 16)
      for (int k = 0; k < 16; k++) chk("t2_fifo", 32'(fq[k]), 32'({4'(k / 4), 4'(k % 4)}));

    // full forced for 3 cycles after the 2nd word; burst resumes and completes.
    restart(16, 0);
    lim[0] = 4;
    for (int n = 0; n < 10 && seq[0] < 2; n++) step(4'h1, 1'b0, 1'b0);
    chk("t3_two", 32'(seq[0]), 32'(2));
    repeat (3) begin
      step(4'h1, 1'b1, 1'b0);
      chk("t3_hold_wr", 32'(last_wr), 32'(0));
      chk("t3_hold_gnt", 32'(last_gnt), 32'h1);
    end
    repeat (10) step(4'h1, 1'b0, 1'b0);
    chk("t3_words", 32'(seq[0]), 32'(4));
    chk("t3_nb", 32'(blog.size()), 32'(1));
    if (blog.size() == 1) chk("t3_b0", 32'(blog[0]), 32'(4));

    // Req 1 drops after 2 words, req 2 takes over.
    restart(16, 0);
    lim[1] = 2; lim[2] = 4;
    repeat (15) step(4'h6, 1'b0, 1'b0);
    chk("t4_ng", 32'(glog.size()), 32'(2));
    if (glog.size() == 2) begin
      chk("t4_g0", 32'(glog[0]), 32'h2);
      chk("t4_g1", 32'(glog[1]), 32'h4);
    end
    if (blog.size() >= 1) chk("t4_b0", 32'(blog[0]), 32'(2));

    // Reset mid-burst with requester 3 granted; arbitration restarts at 0.
    restart(16, 0);
    for (int i = 0; i < 4; i++) lim[i] = 1000;
    for (int n = 0; n < 60 && !(last_gnt == 4'h8 && seq[3] >= 2); n++) step(4'hF, 1'b0, 1'b0);
    chk("t5_reach", 32'(last_gnt == 4'h8 && seq[3] >= 2), 32'(1));
    step(4'hF, 1'b0, 1'b1);
    step(4'hF, 1'b0, 1'b0);
    chk("t5_gnt0", 32'(last_gnt), 32'(0));
    chk("t5_wr0", 32'(last_wr), 32'(0));
    step(4'hF, 1'b0, 1'b0);
    chk("t5_gnt1", 32'(last_gnt), 32'h1);

    // Random valid / backpressure with a depth-2 FIFO and random reads.
    restart(2, 1);
    for (int i = 0; i < 4; i++) lim[i] = 1000000;
    for (int n = 0; n < 5000; n++)
      step(4'($urandom_range(0, 15) | $urandom_range(0, 15)), 1'b0,
           1'($urandom_range(0, 499) == 0));
    while (fq.size() > 0) sb_pop();
    for (int i = 0; i < 4; i++) chk("t6_count", 32'(exp_seq[i]), 32'(seq[i]));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
